// File: rtl/fusion_integrator.sv
// Fusion integrator: per-channel gyro-rate integration with accelerometer
// leak correction, offset calibration and lean gating of one output channel.
// Optional build macro FUSION_SAT_EN: integrators saturate instead of wrapping.
module fusion_integrator #(
    parameter int unsigned        NUM_CH       = 2,
    parameter int unsigned        RATE_W       = 16,
    parameter int unsigned        ACC_W        = 16,
    parameter int unsigned        INT_W        = 24,
    parameter int unsigned        OUT_W        = 13,
    parameter int unsigned        ACC_GAIN     = 327,
    parameter logic [NUM_CH-1:0]  ACC_NEG_MASK = 2'b01,
    parameter int unsigned        ACC_SHIFT    = 13,
    parameter int unsigned        LEAK         = 1024,
    parameter logic [RATE_W-1:0]  RATE_OFS     = 16'h0054,
    parameter int unsigned        CAL_LOG2     = 4,
    parameter int unsigned        GATE_CH      = 0,
    parameter int unsigned        LEAN_CH      = 1,
    parameter int unsigned        THRES        = 152
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vld,
    input  logic [NUM_CH*RATE_W-1:0]   rate,
    input  logic [NUM_CH*ACC_W-1:0]    accel,
    input  logic                       cal_req,
    output logic [NUM_CH*OUT_W-1:0]    angle,
    output logic                       angle_vld,
    output logic                       cal_busy
);

    localparam int unsigned PROD_W = ACC_W + 11;
    localparam int unsigned SUM_W  = RATE_W + CAL_LOG2;
    localparam int unsigned EXT_W  = INT_W + 2;

    localparam logic signed [PROD_W-1:0] GAIN_P = PROD_W'(ACC_GAIN);
    localparam logic signed [PROD_W-1:0] GAIN_N = -GAIN_P;
    localparam logic signed [EXT_W-1:0]  LEAK_E = EXT_W'(LEAK);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_CAL = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_run_smp;
    logic                    w_cal_acc;
    logic                    w_cal_done;
    logic [CAL_LOG2-1:0]     r_cal_cnt;
    logic                    r_cal_busy;
    logic                    r_s0_vld;
    logic                    r_s1_vld;
    logic                    r_s2_vld;
    logic                    r_angle_vld;
    logic signed [OUT_W-1:0] w_top [NUM_CH];
    logic signed [OUT_W:0]   w_lean_ext;
    logic signed [OUT_W:0]   w_lean_abs;
    logic                    w_gate;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: calibration entered on request, left after the last sample
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (cal_req)    w_state_nxt = ST_CAL;
            ST_CAL:  if (w_cal_done) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: route each valid sample to the integrator or the calibrator
    always_comb begin
        w_run_smp  = 1'b0;
        w_cal_acc  = 1'b0;
        w_cal_done = 1'b0;
        case (r_state)
            ST_RUN: w_run_smp = vld;
            ST_CAL: begin
                w_cal_acc  = vld;
                w_cal_done = vld && (r_cal_cnt == '1);
            end
            default: ;
        endcase
    end

    // Calibration sample counter, busy flag and valid pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cal_cnt   <= '0;
            r_cal_busy  <= 1'b0;
            r_s0_vld    <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_angle_vld <= 1'b0;
        end else begin
            if (w_cal_acc) r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
            r_cal_busy  <= (w_state_nxt == ST_CAL);
            r_s0_vld    <= w_run_smp;
            r_s1_vld    <= r_s0_vld;
            r_s2_vld    <= r_s1_vld;
            r_angle_vld <= r_s2_vld;
        end
    end

    // Lean gate: magnitude of the lean channel's fresh integrator top
    assign w_lean_ext = (OUT_W+1)'(w_top[LEAN_CH]);
    assign w_lean_abs = w_lean_ext[OUT_W] ? -w_lean_ext : w_lean_ext;
    assign w_gate     = w_lean_abs > (OUT_W+1)'(THRES);

    assign angle_vld = r_angle_vld;
    assign cal_busy  = r_cal_busy;

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        localparam bit IS_GATE = (gc == GATE_CH);

        logic signed [RATE_W-1:0] w_rate_in;
        logic signed [RATE_W-1:0] r_s0_rate;
        logic signed [ACC_W-1:0]  r_s0_acc;
        logic signed [RATE_W-1:0] r_offset;
        logic signed [SUM_W-1:0]  r_cal_sum;
        logic signed [SUM_W-1:0]  w_cal_nxt;
        logic signed [RATE_W:0]   w_diff;
        logic signed [PROD_W-1:0] w_prod;
        logic signed [INT_W-1:0]  r_s1_comp;
        logic signed [OUT_W-1:0]  r_s1_acc_ang;
        logic signed [INT_W-1:0]  r_int;
        logic signed [INT_W-1:0]  w_int_nxt;
        logic signed [EXT_W-1:0]  w_sum;
        logic                     w_leak_up;
        logic signed [OUT_W-1:0]  r_angle;

        assign w_rate_in = $signed(rate[gc*RATE_W +: RATE_W]);
        assign w_cal_nxt = r_cal_sum + SUM_W'(w_rate_in);
        assign w_diff    = (RATE_W+1)'(r_s0_rate) - (RATE_W+1)'(r_offset);
        assign w_prod    = PROD_W'(r_s0_acc) * (ACC_NEG_MASK[gc] ? GAIN_N : GAIN_P);
        assign w_top[gc] = OUT_W'(r_int >>> (INT_W - OUT_W));
        assign w_leak_up = r_s1_acc_ang > w_top[gc];
        assign w_sum     = EXT_W'(r_int) + EXT_W'(r_s1_comp)
                         + (w_leak_up ? LEAK_E : -LEAK_E);
        assign angle[gc*OUT_W +: OUT_W] = r_angle;

        // Integrator next value: wrap, or clamp when saturation is built in
        always_comb begin
            w_int_nxt = INT_W'(w_sum);
`ifdef FUSION_SAT_EN
            if (w_sum > EXT_W'($signed({1'b0, {(INT_W-1){1'b1}}})))
                w_int_nxt = {1'b0, {(INT_W-1){1'b1}}};
            else if (w_sum < EXT_W'($signed({1'b1, {(INT_W-1){1'b0}}})))
                w_int_nxt = {1'b1, {(INT_W-1){1'b0}}};
`endif
        end

        // Offset calibration: accumulate raw rates, average after the last sample
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_offset  <= RATE_OFS;
                r_cal_sum <= '0;
            end else if (w_cal_acc) begin
                if (w_cal_done) begin
                    r_offset  <= RATE_W'(w_cal_nxt >>> CAL_LOG2);
                    r_cal_sum <= '0;
                end else begin
                    r_cal_sum <= w_cal_nxt;
                end
            end
        end

        // Input capture and stage 1: offset-compensated rate and accel angle
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s0_rate    <= '0;
                r_s0_acc     <= '0;
                r_s1_comp    <= '0;
                r_s1_acc_ang <= '0;
            end else begin
                r_s0_rate    <= w_rate_in;
                r_s0_acc     <= $signed(accel[gc*ACC_W +: ACC_W]);
                r_s1_comp    <= INT_W'(w_diff);
                r_s1_acc_ang <= OUT_W'(w_prod >>> ACC_SHIFT);
            end
        end

        // Stage 2 integrator and stage 3 angle output with lean gating
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_int   <= '0;
                r_angle <= '0;
            end else begin
                if (r_s1_vld) r_int   <= w_int_nxt;
                if (r_s2_vld) r_angle <= (IS_GATE && w_gate) ? '0 : w_top[gc];
            end
        end
    end

endmodule

// File: tb/tb_fusion_integrator.sv
// Directed bench for fusion_integrator (default parameters).
module tb_fusion_integrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [31:0] rate;
    logic [31:0] accel;
    logic        cal_req;
    logic [25:0] angle;
    logic        angle_vld;
    logic        cal_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] r0, r1, a0, a1;
        logic [12:0] e0, e1;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    fusion_integrator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .rate      (rate),
        .accel     (accel),
        .cal_req   (cal_req),
        .angle     (angle),
        .angle_vld (angle_vld),
        .cal_busy  (cal_busy)
    );

    function automatic logic [12:0] ang(input int c);
        return angle[c*13 +: 13];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vld = 1'b0; cal_req = 1'b0; rate = '0; accel = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One sample, then wait (bounded) for its angle_vld; lat = edges until seen
    task automatic one_sample(input logic [15:0] r0, r1, a0, a1, output int lat);
        rate = {r1, r0}; accel = {a1, a0}; vld = 1'b1;
        tick();
        vld = 1'b0;
        lat = 1;
        while (angle_vld !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        if (angle_vld !== 1'b1) lat = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int pulses;
        logic [12:0] exp0;

        vecs[0] = '{16'h0054, 16'h0054, 16'h0000, 16'h0000, 13'h1FFF, 13'h1FFF};
        vecs[1] = '{16'h0054, 16'h0054, 16'h0000, 16'h0000, 13'h0000, 13'h0000};
        vecs[2] = '{16'h0454, 16'h0454, 16'h03E8, 16'h03E8, 13'h0000, 13'h0001};
        vecs[3] = '{16'hF854, 16'h1454, 16'hFC18, 16'hF830, 13'h1FFF, 13'h0003};
        vecs[4] = '{16'h0854, 16'h0054, 16'h0001, 16'h004C, 13'h0000, 13'h0002};

        // Reset state
        do_reset();
        check("reset angle", 32'(angle), 32'h0);
        check("reset angle_vld", 32'(angle_vld), 32'h0);
        check("reset cal_busy", 32'(cal_busy), 32'h0);

        // Table: sequential single samples, state carried between vectors
        for (int i = 0; i < 5; i++) begin
            one_sample(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d angle0", i), 32'(ang(0)), 32'(vecs[i].e0));
            check($sformatf("vec%0d angle1", i), 32'(ang(1)), 32'(vecs[i].e1));
        end

        // Back-to-back valids: one pulse per sample, 4 cycles after each
        do_reset();
        rate = {16'h0054, 16'h0054}; accel = '0;
        pulses = 0;
        for (int t = 0; t < 16; t++) begin
            vld = (t < 8);
            tick();
            if (angle_vld) pulses++;
            check($sformatf("b2b angle_vld t%0d", t), 32'(angle_vld), 32'((t >= 3) && (t < 11)));
            if (t >= 3 && t < 11) begin
                exp0 = ((t - 3) % 2 == 0) ? 13'h1FFF : 13'h0000;
                check($sformatf("b2b angle0 t%0d", t), 32'(ang(0)), 32'(exp0));
            end
        end
        check("b2b pulse count", 32'(pulses), 32'd8);

        // Calibration: same-cycle sample integrates, in-flight sample completes
        do_reset();
        for (int t = 0; t < 21; t++) begin
            cal_req = (t == 0 || t == 5);
            vld     = (t <= 16);
            rate    = (t == 0) ? {16'h0054, 16'h0054} : {16'h0030, 16'h0030};
            tick();
            check($sformatf("cal angle_vld t%0d", t), 32'(angle_vld), 32'(t == 3));
            check($sformatf("cal busy t%0d", t), 32'(cal_busy), 32'(t <= 15));
            if (t == 3) check("cal inflight angle", 32'(angle), {6'h0, 13'h1FFF, 13'h1FFF});
        end
        cal_req = 1'b0; vld = 1'b0;
        one_sample(16'h0030, 16'h0030, 16'h0, 16'h0, lat);
        check("post-cal latency", 32'(lat), 32'd4);
        check("post-cal angle a", 32'(angle), 32'h0);
        one_sample(16'h0030, 16'h0030, 16'h0, 16'h0, lat);
        check("post-cal angle b", 32'(angle), {6'h0, 13'h1FFF, 13'h1FFF});

        // Reset in the middle of calibration
        for (int t = 0; t < 8; t++) begin
            cal_req = (t == 0);
            vld     = (t >= 1);
            rate    = {16'h0030, 16'h0030};
            tick();
        end
        check("mid-cal busy", 32'(cal_busy), 32'h1);
        vld = 1'b0; cal_req = 1'b0; rst_n = 1'b0;
        tick();
        check("mid-cal rst busy", 32'(cal_busy), 32'h0);
        check("mid-cal rst angle", 32'(angle), 32'h0);
        check("mid-cal rst angle_vld", 32'(angle_vld), 32'h0);
        rst_n = 1'b1;
        one_sample(16'h0C53, 16'h0C53, 16'h0, 16'h0, lat);
        check("offset restored", 32'(angle), 32'h0);

        // Fresh calibration after the aborted one must start from empty sums
        for (int t = 0; t < 20; t++) begin
            cal_req = (t == 0);
            vld     = (t >= 1 && t <= 16);
            rate    = {16'h0830, 16'h0830};
            tick();
        end
        cal_req = 1'b0;
        check("recal busy done", 32'(cal_busy), 32'h0);
        one_sample(16'h0C31, 16'h0C31, 16'h0, 16'h0, lat);
        check("recal offset", 32'(angle), {6'h0, 13'h0001, 13'h0001});

        // Lean gating of channel 0 driven by channel 1's integrator
        do_reset();
        for (int k = 0; k < 10; k++) one_sample(16'h0C54, 16'h7C54, 16'h0, 16'h0, lat);
        check("lean150 angle0", 32'(ang(0)), 32'd10);
        check("lean150 angle1", 32'(ang(1)), 32'd150);
        one_sample(16'h0C54, 16'h1C54, 16'h0, 16'h0, lat);
        check("lean153 angle0 gated", 32'(ang(0)), 32'd0);
        check("lean153 angle1", 32'(ang(1)), 32'd153);
        one_sample(16'h0C54, 16'hFC54, 16'h0, 16'h0, lat);
        check("lean152 angle0", 32'(ang(0)), 32'd12);
        check("lean152 angle1", 32'(ang(1)), 32'd152);

        // Full-scale rate for 300 samples: saturate or wrap
        do_reset();
        rate = {16'h0054, 16'h7FFF}; accel = '0;
        pulses = 0;
        for (int t = 0; t < 310; t++) begin
            vld = (t < 300);
            tick();
            if (angle_vld) pulses++;
        end
        check("sat pulse count", 32'(pulses), 32'd300);
`ifdef FUSION_SAT_EN
        check("sat angle0", 32'(ang(0)), 32'h0FFF);
`else
        check("wrap angle0 sign", 32'(ang(0) >> 12), 32'h1);
        check("wrap angle0", 32'(ang(0)), 32'h1240);
`endif
        check("sat angle1", 32'(ang(1)), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fusion_integrator.md
FUSION_INTEGRATOR -- requirements
Module: fusion_integrator

Interface
REQ-001 Parameter NUM_CH, default 2: number of rate/accel channel pairs.
REQ-002 Parameter RATE_W, default 16: signed gyro rate width; ACC_W, default 16: signed accel width.
REQ-003 Parameter INT_W, default 24: integrator width; OUT_W, default 13: angle output width, taken as integrator bits [INT_W-1 -: OUT_W].
REQ-004 Parameter ACC_GAIN, default 327; ACC_NEG_MASK, default 2'b01: a set bit negates the gain for that channel; ACC_SHIFT, default 13.
REQ-005 Parameter LEAK, default 1024: fusion step added to or subtracted from the integrator on each sample.
REQ-006 Parameter RATE_OFS, default 16'h0054: reset value of every per-channel rate offset; CAL_LOG2, default 4: log2 of the calibration sample count.
REQ-007 Parameters GATE_CH, default 0; LEAN_CH, default 1; THRES, default 152: lean gating of one output channel.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst_n  input  1  synchronous, active-low reset.
REQ-010 vld  input  1  one-cycle pulse: rate/accel valid this cycle.
REQ-011 rate  input  NUM_CH*RATE_W  packed signed gyro rates, channel 0 in the LSBs.
REQ-012 accel  input  NUM_CH*ACC_W  packed signed accel readings, channel 0 in the LSBs.
REQ-013 cal_req  input  1  pulse: start offset calibration.
REQ-014 angle  output  NUM_CH*OUT_W  packed signed fused angles, registered.
REQ-015 angle_vld  output  1  one-cycle pulse: angle updated.
REQ-016 cal_busy  output  1  high while in CAL.

Function
REQ-017 Pipeline: vld captured at edge E; stage 1 registers the compensated rate (rate-offset, sign-extended to INT_W) and the accel products at E+1; integrators update at E+2; angle registers at E+3; angle_vld high for the cycle after E+3.
REQ-018 vld asserted on every cycle is fully supported: one angle_vld pulse per vld, no sample dropped.
REQ-019 acc_angle[c] = bits [ACC_SHIFT+OUT_W-1 : ACC_SHIFT] of accel[c]*(±ACC_GAIN), product width ACC_W+11.
REQ-020 int[c] <= int[c] + comp_rate[c] + (acc_angle[c] > int_top[c] ? +LEAK : -LEAK); equality gives -LEAK.
REQ-021 Lean gate: when |int_top[LEAN_CH]| > THRES for the same sample, angle[GATE_CH] registers 0; the integrator itself is unaffected.
REQ-022 FSM states RUN and CAL; reset enters RUN; cal_req in RUN -> CAL on the next edge; cal_req in CAL is ignored.
REQ-023 CAL: integrators hold and angle_vld stays low; each vld adds the raw rate to a per-channel sum of width RATE_W+CAL_LOG2; after 2^CAL_LOG2 samples, offset[c] <= sum >>> CAL_LOG2, sums clear, state -> RUN.
REQ-024 Samples already in the pipeline when CAL is entered complete normally.
REQ-025 cal_req and vld in the same RUN cycle: that sample is integrated, not calibrated.

Reset
REQ-026 With rst_n low at an edge: integrators, sums, pipeline registers, angle, angle_vld and cal_busy go to 0; offsets go to RATE_OFS; state goes to RUN; this holds mid-calibration too.

Configuration
REQ-027 Macro FUSION_SAT_EN: when defined, the integrator sum saturates to the signed INT_W range; when undefined, it wraps in two's complement.

Verification
REQ-028 Reset, rate0=0x0054, accel=0, one vld -> angle_vld 4 cycles later, angle[ch0]=13'h1FFF (int=-1024).
REQ-029 cal_req, then 16 vld with rate=0x0030 on all channels -> cal_busy falls, offset=0x0030; next sample with rate=0x0030 changes the integrator by ±LEAK only.
REQ-030 rate0=0x7FFF, accel=0, 300 samples -> with FUSION_SAT_EN, angle[ch0] holds 13'h0FFF; without it, angle[ch0] wraps negative.
REQ-031 Drive LEAN_CH until |angle| reaches 153 -> angle[GATE_CH]=0 while its integrator is nonzero; at 152 or below the output is restored.
REQ-032 rst_n low after 7 of 16 calibration samples -> cal_busy=0, offsets=0x0054, angle=0 on the next cycle.
REQ-033 vld held high for 8 cycles -> exactly 8 angle_vld pulses, each 4 cycles after its vld.
